// File: rtl/phys_tag_free_list_if.sv
// ---------------------------------------------------------------------------
// phys_tag_free_list_if
//
// Bundles the rename-side allocation handshake and the commit-side release
// bus of the physical tag free list.
//
//   alloc_req_i   [LANES]        per-lane destination-tag request (lane 0 oldest)
//   alloc_gnt_o   [LANES]        per-lane grant, combinational
//   alloc_tag_o   [LANES][TAG_W] granted tag per lane, 0 when not granted
//   alloc_stall_o                request present but not satisfiable
//   free_valid_i  [LANES]        per-lane tag release from commit
//   free_tag_i    [LANES][TAG_W] tags being released
//   free_count_o  [TAG_W+1]      tags currently in the pool, registered
//   error_o                      sticky overflow flag, registered
//
// master: the rename/commit side driving requests and releases.
// slave : the free list itself.
// ---------------------------------------------------------------------------
interface phys_tag_free_list_if #(
    parameter int TAG_W = 6,
    parameter int LANES = 3
);
    logic [LANES-1:0]            alloc_req_i;
    logic [LANES-1:0]            alloc_gnt_o;
    logic [LANES-1:0][TAG_W-1:0] alloc_tag_o;
    logic                        alloc_stall_o;
    logic [LANES-1:0]            free_valid_i;
    logic [LANES-1:0][TAG_W-1:0] free_tag_i;
    logic [TAG_W:0]              free_count_o;
    logic                        error_o;

    modport master (
        output alloc_req_i,
        output free_valid_i,
        output free_tag_i,
        input  alloc_gnt_o,
        input  alloc_tag_o,
        input  alloc_stall_o,
        input  free_count_o,
        input  error_o
    );

    modport slave (
        input  alloc_req_i,
        input  free_valid_i,
        input  free_tag_i,
        output alloc_gnt_o,
        output alloc_tag_o,
        output alloc_stall_o,
        output free_count_o,
        output error_o
    );
endinterface

// File: rtl/phys_tag_free_list.sv
// ---------------------------------------------------------------------------
// phys_tag_free_list
//
// Pool of unmapped physical register tags for the rename stage, kept as a
// circular FIFO. Up to three tags are granted per cycle (all-or-nothing) and
// up to three released tags are returned per cycle.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous reset, active low
//   fl   - phys_tag_free_list_if.slave: allocation handshake, release bus,
//          pool occupancy and sticky overflow flag
//
// At reset the pool holds tags NUM_ARCH..NUM_TAGS-1 in ascending order; tags
// below NUM_ARCH belong to the reset-time architectural mapping.
// ---------------------------------------------------------------------------
module phys_tag_free_list #(
    parameter int TAG_W    = 6,
    parameter int NUM_TAGS = 64,
    parameter int NUM_ARCH = 15
) (
    input logic                  clk,
    input logic                  rst,
    phys_tag_free_list_if.slave  fl
);

    localparam int LANES = 3;
    localparam int CNT_W = TAG_W + 1;
    localparam int CAP_I = NUM_TAGS - NUM_ARCH;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAP_I);

    // Number of set bits in a lane mask.
    function automatic logic [1:0] popcount3(input logic [LANES-1:0] v);
        logic [1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            s = s + {1'b0, v[i]};
        end
        return s;
    endfunction

    // State
    logic [TAG_W-1:0] entry_q [NUM_TAGS];
    logic [TAG_W-1:0] entry_d [NUM_TAGS];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    // Combinational working signals
    logic [1:0]                  n_a;
    logic [1:0]                  n_f;
    logic [1:0]                  n_take;
    logic                        alloc_ok;
    logic                        overflow;
    logic [CNT_W-1:0]            count_sum;
    logic [1:0]                  a_rank;
    logic [1:0]                  f_rank;
    logic [LANES-1:0]            gnt;
    logic [LANES-1:0][TAG_W-1:0] tag;
    logic                        stall;

    always_comb begin
        n_a      = popcount3(fl.alloc_req_i);
        n_f      = popcount3(fl.free_valid_i);
        alloc_ok = (count_q >= CNT_W'(n_a));
        n_take   = alloc_ok ? n_a : 2'd0;

        // count_q never exceeds CAP, so the sum cannot wrap CNT_W bits.
        count_sum = count_q - CNT_W'(n_take) + CNT_W'(n_f);
        overflow  = (count_sum > CAP);

        gnt   = alloc_ok ? fl.alloc_req_i : '0;
        stall = (n_a != 2'd0) && !alloc_ok;

        // Requesting lanes are compacted onto consecutive FIFO slots so a
        // sparse request mask still consumes tags strictly in order. Only
        // registered entries are read: same-cycle frees are never granted.
        a_rank = '0;
        for (int k = 0; k < LANES; k++) begin
            tag[k] = '0;
            if (fl.alloc_req_i[k]) begin
                if (alloc_ok) begin
                    tag[k] = entry_q[head_q + TAG_W'(a_rank)];
                end
                a_rank = a_rank + 2'd1;
            end
        end

        // Released tags are appended compacted at the tail; an overflowing
        // cycle drops every release so the pool never exceeds CAP.
        for (int i = 0; i < NUM_TAGS; i++) begin
            entry_d[i] = entry_q[i];
        end
        f_rank = '0;
        for (int k = 0; k < LANES; k++) begin
            if (fl.free_valid_i[k]) begin
                if (!overflow) begin
                    entry_d[tail_q + TAG_W'(f_rank)] = fl.free_tag_i[k];
                end
                f_rank = f_rank + 2'd1;
            end
        end

        // Pointers are TAG_W wide and NUM_TAGS is 2**TAG_W, so they wrap
        // modulo the array depth without explicit handling.
        head_d  = head_q + TAG_W'(n_take);
        tail_d  = overflow ? tail_q : (tail_q + TAG_W'(n_f));
        count_d = overflow ? (count_q - CNT_W'(n_take)) : count_sum;
        error_d = error_q | overflow;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                entry_q[i] <= (i < CAP_I) ? TAG_W'(i + NUM_ARCH) : '0;
            end
            head_q  <= '0;
            tail_q  <= TAG_W'(CAP_I);
            count_q <= CAP;
            error_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                entry_q[i] <= entry_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign fl.alloc_gnt_o   = gnt;
    assign fl.alloc_tag_o   = tag;
    assign fl.alloc_stall_o = stall;
    assign fl.free_count_o  = count_q;
    assign fl.error_o       = error_q;

endmodule

// File: tb/tb_phys_tag_free_list.sv
// ---------------------------------------------------------------------------
// tb_phys_tag_free_list
//
// Directed bench for phys_tag_free_list. Inputs change on the falling edge;
// combinational outputs are sampled 1ns later, registered outputs 1ns after
// the rising edge. A queue mirrors the expected FIFO contents of the pool.
// ---------------------------------------------------------------------------
module tb_phys_tag_free_list;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    phys_tag_free_list_if #(.TAG_W(6), .LANES(3)) fl ();

    phys_tag_free_list #(.TAG_W(6), .NUM_TAGS(64), .NUM_ARCH(15)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    int checks = 0;
    int errors = 0;
    int q[$];

    task automatic drive(input logic [2:0] req, input logic [2:0] fv,
                         input int t0, input int t1, input int t2);
        fl.alloc_req_i   = req;
        fl.free_valid_i  = fv;
        fl.free_tag_i[0] = 6'(t0);
        fl.free_tag_i[1] = 6'(t1);
        fl.free_tag_i[2] = 6'(t2);
    endtask

    task automatic test_reset;
        q.delete();
        for (int i = 15; i < 64; i++) q.push_back(i);
        drive(3'b111, 3'b000, 0, 0, 0);
        #1 rst = 1'b0;
        #2;
        checks++;
        if (fl.free_count_o !== 7'd49) begin
            errors++; $display("FAIL reset_count got %0d want 49", fl.free_count_o);
        end
        checks++;
        if (fl.error_o !== 1'b0) begin
            errors++; $display("FAIL reset_error got %b want 0", fl.error_o);
        end
        checks++;
        if (fl.alloc_tag_o[0] !== 6'd15 || fl.alloc_tag_o[1] !== 6'd16 || fl.alloc_tag_o[2] !== 6'd17) begin
            errors++; $display("FAIL reset_tags got %0d/%0d/%0d want 15/16/17",
                               fl.alloc_tag_o[0], fl.alloc_tag_o[1], fl.alloc_tag_o[2]);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000, 3'b000, 0, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd49) begin
            errors++; $display("FAIL idle_count got %0d want 49", fl.free_count_o);
        end
    endtask

    task automatic test_alloc_three;
        @(negedge clk);
        drive(3'b111, 3'b000, 0, 0, 0);
        #1;
        checks++;
        if (fl.alloc_gnt_o !== 3'b111 || fl.alloc_stall_o !== 1'b0) begin
            errors++; $display("FAIL alloc3_gnt got %b stall %b want 111 stall 0",
                               fl.alloc_gnt_o, fl.alloc_stall_o);
        end
        checks++;
        if (fl.alloc_tag_o[0] !== 6'd15 || fl.alloc_tag_o[1] !== 6'd16 || fl.alloc_tag_o[2] !== 6'd17) begin
            errors++; $display("FAIL alloc3_tags got %0d/%0d/%0d want 15/16/17",
                               fl.alloc_tag_o[0], fl.alloc_tag_o[1], fl.alloc_tag_o[2]);
        end
        repeat (3) void'(q.pop_front());
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd46) begin
            errors++; $display("FAIL alloc3_count got %0d want 46", fl.free_count_o);
        end
    endtask

    task automatic test_sparse;
        @(negedge clk);
        drive(3'b101, 3'b000, 0, 0, 0);
        #1;
        checks++;
        if (fl.alloc_gnt_o !== 3'b101) begin
            errors++; $display("FAIL sparse_gnt got %b want 101", fl.alloc_gnt_o);
        end
        checks++;
        if (fl.alloc_tag_o[0] !== 6'd18 || fl.alloc_tag_o[1] !== 6'd0 || fl.alloc_tag_o[2] !== 6'd19) begin
            errors++; $display("FAIL sparse_tags got %0d/%0d/%0d want 18/0/19",
                               fl.alloc_tag_o[0], fl.alloc_tag_o[1], fl.alloc_tag_o[2]);
        end
        repeat (2) void'(q.pop_front());
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd44) begin
            errors++; $display("FAIL sparse_count got %0d want 44", fl.free_count_o);
        end
    endtask

    task automatic test_stall;
        // 14 full grants take tags 20..61, leaving 62 and 63.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(3'b111, 3'b000, 0, 0, 0);
            #1;
            checks++;
            if (fl.alloc_tag_o[0] !== 6'(20 + 3 * i) || fl.alloc_tag_o[2] !== 6'(22 + 3 * i)) begin
                errors++; $display("FAIL drain_tags step %0d got %0d/%0d want %0d/%0d", i,
                                   fl.alloc_tag_o[0], fl.alloc_tag_o[2], 20 + 3 * i, 22 + 3 * i);
            end
            repeat (3) void'(q.pop_front());
            @(posedge clk);
        end
        #1;
        checks++;
        if (fl.free_count_o !== 7'd2) begin
            errors++; $display("FAIL drain_count got %0d want 2", fl.free_count_o);
        end
        @(negedge clk);
        drive(3'b111, 3'b000, 0, 0, 0);
        #1;
        checks++;
        if (fl.alloc_gnt_o !== 3'b000 || fl.alloc_stall_o !== 1'b1 || fl.alloc_tag_o[0] !== 6'd0) begin
            errors++; $display("FAIL stall3 got gnt %b stall %b tag0 %0d want 000 1 0",
                               fl.alloc_gnt_o, fl.alloc_stall_o, fl.alloc_tag_o[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd2) begin
            errors++; $display("FAIL stall_count got %0d want 2", fl.free_count_o);
        end
        @(negedge clk);
        drive(3'b011, 3'b000, 0, 0, 0);
        #1;
        checks++;
        if (fl.alloc_gnt_o !== 3'b011 || fl.alloc_stall_o !== 1'b0 ||
            fl.alloc_tag_o[0] !== 6'd62 || fl.alloc_tag_o[1] !== 6'd63 || fl.alloc_tag_o[2] !== 6'd0) begin
            errors++; $display("FAIL last2 got gnt %b tags %0d/%0d/%0d want 011 62/63/0",
                               fl.alloc_gnt_o, fl.alloc_tag_o[0], fl.alloc_tag_o[1], fl.alloc_tag_o[2]);
        end
        repeat (2) void'(q.pop_front());
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd0) begin
            errors++; $display("FAIL empty_count got %0d want 0", fl.free_count_o);
        end
    endtask

    task automatic test_empty_free;
        @(negedge clk);
        drive(3'b001, 3'b111, 5, 40, 7);
        #1;
        checks++;
        if (fl.alloc_stall_o !== 1'b1 || fl.alloc_gnt_o !== 3'b000) begin
            errors++; $display("FAIL empty_stall got stall %b gnt %b want 1 000",
                               fl.alloc_stall_o, fl.alloc_gnt_o);
        end
        q.push_back(5); q.push_back(40); q.push_back(7);
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd3) begin
            errors++; $display("FAIL refill_count got %0d want 3", fl.free_count_o);
        end
        @(negedge clk);
        drive(3'b001, 3'b000, 0, 0, 0);
        #1;
        checks++;
        if (fl.alloc_gnt_o !== 3'b001 || fl.alloc_tag_o[0] !== 6'd5) begin
            errors++; $display("FAIL reuse_tag got gnt %b tag %0d want 001 5",
                               fl.alloc_gnt_o, fl.alloc_tag_o[0]);
        end
        void'(q.pop_front());
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd2) begin
            errors++; $display("FAIL reuse_count got %0d want 2", fl.free_count_o);
        end
    endtask

    task automatic test_back_to_back;
        int e0, e1, e2;
        @(negedge clk);
        drive(3'b000, 3'b111, 20, 21, 22);
        q.push_back(20); q.push_back(21); q.push_back(22);
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd5) begin
            errors++; $display("FAIL b2b_prefill got %0d want 5", fl.free_count_o);
        end
        // Head starts at 50 and moves by 3, so grants straddle 63->0 repeatedly.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            e0 = q.pop_front(); e1 = q.pop_front(); e2 = q.pop_front();
            drive(3'b111, 3'b111, e0, e1, e2);
            q.push_back(e0); q.push_back(e1); q.push_back(e2);
            #1;
            checks++;
            if (fl.alloc_gnt_o !== 3'b111 || fl.alloc_stall_o !== 1'b0 ||
                fl.alloc_tag_o[0] !== 6'(e0) || fl.alloc_tag_o[1] !== 6'(e1) || fl.alloc_tag_o[2] !== 6'(e2)) begin
                errors++; $display("FAIL b2b cycle %0d got gnt %b stall %b tags %0d/%0d/%0d want 111 0 %0d/%0d/%0d",
                                   i, fl.alloc_gnt_o, fl.alloc_stall_o, fl.alloc_tag_o[0],
                                   fl.alloc_tag_o[1], fl.alloc_tag_o[2], e0, e1, e2);
            end
            @(posedge clk); #1;
            checks++;
            if (fl.free_count_o !== 7'd5) begin
                errors++; $display("FAIL b2b_count cycle %0d got %0d want 5", i, fl.free_count_o);
            end
        end
    endtask

    task automatic test_overflow;
        int e0, e1, e2;
        // Release 44 tags (0..43, including architectural ones) to fill the pool.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(3'b000, 3'b111, 3 * i, 3 * i + 1, 3 * i + 2);
            q.push_back(3 * i); q.push_back(3 * i + 1); q.push_back(3 * i + 2);
        end
        @(negedge clk);
        drive(3'b000, 3'b011, 42, 43, 0);
        q.push_back(42); q.push_back(43);
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd49 || fl.error_o !== 1'b0) begin
            errors++; $display("FAIL full_state got count %0d err %b want 49 0", fl.free_count_o, fl.error_o);
        end
        @(negedge clk);
        drive(3'b000, 3'b001, 50, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd49 || fl.error_o !== 1'b1) begin
            errors++; $display("FAIL overflow got count %0d err %b want 49 1", fl.free_count_o, fl.error_o);
        end
        // Balanced alloc+free at full is legal; tag 55 must land where 50 was dropped.
        @(negedge clk);
        e0 = q.pop_front();
        drive(3'b001, 3'b001, 55, 0, 0);
        q.push_back(55);
        #1;
        checks++;
        if (fl.alloc_gnt_o !== 3'b001 || fl.alloc_tag_o[0] !== 6'(e0)) begin
            errors++; $display("FAIL full_swap got gnt %b tag %0d want 001 %0d", fl.alloc_gnt_o, fl.alloc_tag_o[0], e0);
        end
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd49 || fl.error_o !== 1'b1) begin
            errors++; $display("FAIL sticky got count %0d err %b want 49 1", fl.free_count_o, fl.error_o);
        end
        // Drain the whole pool and compare against the reference order.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i < 16) begin
                e0 = q.pop_front(); e1 = q.pop_front(); e2 = q.pop_front();
                drive(3'b111, 3'b000, 0, 0, 0);
            end else begin
                e0 = q.pop_front(); e1 = 0; e2 = 0;
                drive(3'b001, 3'b000, 0, 0, 0);
            end
            #1;
            checks++;
            if (fl.alloc_tag_o[0] !== 6'(e0) || fl.alloc_tag_o[1] !== 6'(e1) || fl.alloc_tag_o[2] !== 6'(e2)) begin
                errors++; $display("FAIL final_drain step %0d got %0d/%0d/%0d want %0d/%0d/%0d", i,
                                   fl.alloc_tag_o[0], fl.alloc_tag_o[1], fl.alloc_tag_o[2], e0, e1, e2);
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if (fl.free_count_o !== 7'd0) begin
            errors++; $display("FAIL final_empty got %0d want 0", fl.free_count_o);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        drive(3'b111, 3'b000, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (fl.error_o !== 1'b0 || fl.free_count_o !== 7'd49) begin
            errors++; $display("FAIL midreset got err %b count %0d want 0 49", fl.error_o, fl.free_count_o);
        end
        checks++;
        if (fl.alloc_tag_o[0] !== 6'd15 || fl.alloc_tag_o[2] !== 6'd17) begin
            errors++; $display("FAIL midreset_tags got %0d/%0d want 15/17", fl.alloc_tag_o[0], fl.alloc_tag_o[2]);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(3'b001, 3'b000, 0, 0, 0);
        #1;
        checks++;
        if (fl.alloc_gnt_o !== 3'b001 || fl.alloc_tag_o[0] !== 6'd15) begin
            errors++; $display("FAIL post_reset got gnt %b tag %0d want 001 15", fl.alloc_gnt_o, fl.alloc_tag_o[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (fl.free_count_o !== 7'd48) begin
            errors++; $display("FAIL post_reset_count got %0d want 48", fl.free_count_o);
        end
        @(negedge clk);
        drive(3'b000, 3'b000, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_alloc_three();
        test_sparse();
        test_stall();
        test_empty_free();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
